// File: rtl/ep01_sweep_capture.sv
// Truth-table sweeper: drives every input vector in ascending order, samples f after SETTLE cycles.
// Optional EP01_EXPECT_CHECK_EN adds an expected-table comparison with first-error capture.
module ep01_sweep_capture #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  f_in_i,
`ifdef EP01_EXPECT_CHECK_EN
  input  logic [2**N_IN-1:0]    expected_i,
  output logic                  mismatch_o,
  output logic [N_IN-1:0]       first_err_o,
`endif
  output logic [N_IN-1:0]       vec_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2**N_IN-1:0]    table_out_o,
  output logic [N_IN:0]         ones_count_o
);

  localparam int unsigned TblW = 2**N_IN;
  localparam logic [7:0] CntLast = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [N_IN-1:0]   vec_q;
  logic              busy_q;
  logic              done_q;
  logic [TblW-1:0]   table_q;
  logic [N_IN:0]     ones_q;
`ifdef EP01_EXPECT_CHECK_EN
  logic              mismatch_q;
  logic [N_IN-1:0]   first_err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_q     <= '0;
      ones_q      <= '0;
`ifdef EP01_EXPECT_CHECK_EN
      mismatch_q  <= 1'b0;
      first_err_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            vec_q       <= '0;
            cnt_q       <= '0;
            table_q     <= '0;
            ones_q      <= '0;
`ifdef EP01_EXPECT_CHECK_EN
            mismatch_q  <= 1'b0;
            first_err_q <= '0;
`endif
          end
        end
        StRun: begin
          if (abort_i) begin
            // Partial capture is deliberately kept for inspection.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            table_q[vec_q] <= f_in_i;
            ones_q         <= ones_q + {{N_IN{1'b0}}, f_in_i};
            cnt_q          <= '0;
`ifdef EP01_EXPECT_CHECK_EN
            if (f_in_i != expected_i[vec_q]) begin
              mismatch_q <= 1'b1;
              if (!mismatch_q) first_err_q <= vec_q;
            end
`endif
            if (vec_q == VecLast) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec_o        = vec_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign table_out_o  = table_q;
  assign ones_count_o = ones_q;
`ifdef EP01_EXPECT_CHECK_EN
  assign mismatch_o   = mismatch_q;
  assign first_err_o  = first_err_q;
`endif

endmodule

// File: tb/tb_ep01_sweep_capture.sv
// Directed bench for ep01_sweep_capture: two instances (SETTLE=1 and SETTLE=3) share clock/reset.
module tb_ep01_sweep_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  int   mode = 0;
  int   num_checks = 0;
  int   num_fail = 0;

  logic [3:0]  vec_a, vec_b;
  logic        busy_a, busy_b, done_a, done_b, f_a, f_b;
  logic [15:0] tbl_a, tbl_b;
  logic [4:0]  ones_a, ones_b;
`ifdef EP01_EXPECT_CHECK_EN
  logic [15:0] exp_tbl = 16'hAAAA;
  logic        mis_a, mis_b;
  logic [3:0]  ferr_a, ferr_b;
`endif

  function automatic logic fmodel(input int m, input logic [3:0] v);
    case (m)
      1:       return v[0];
      2:       return (v[3] & v[2]) | (v[1] & ~v[0]);
      3:       return v[0] | (v == 4'd4) | (v == 4'd6);
      default: return 1'b1;
    endcase
  endfunction

  assign f_a = fmodel(mode, vec_a);
  assign f_b = fmodel(mode, vec_b);

  ep01_sweep_capture #(.N_IN(4), .SETTLE(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a), .f_in_i(f_a),
`ifdef EP01_EXPECT_CHECK_EN
    .expected_i(exp_tbl), .mismatch_o(mis_a), .first_err_o(ferr_a),
`endif
    .vec_o(vec_a), .busy_o(busy_a), .done_o(done_a), .table_out_o(tbl_a), .ones_count_o(ones_a)
  );

  ep01_sweep_capture #(.N_IN(4), .SETTLE(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b), .f_in_i(f_b),
`ifdef EP01_EXPECT_CHECK_EN
    .expected_i(exp_tbl), .mismatch_o(mis_b), .first_err_o(ferr_b),
`endif
    .vec_o(vec_b), .busy_o(busy_b), .done_o(done_b), .table_out_o(tbl_b), .ones_count_o(ones_b)
  );

  int          sel = 0;
  logic [3:0]  vec_s;
  logic        busy_s, done_s;
  logic [15:0] tbl_s;
  logic [4:0]  ones_s;
  assign vec_s  = (sel != 0) ? vec_b  : vec_a;
  assign busy_s = (sel != 0) ? busy_b : busy_a;
  assign done_s = (sel != 0) ? done_b : done_a;
  assign tbl_s  = (sel != 0) ? tbl_b  : tbl_a;
  assign ones_s = (sel != 0) ? ones_b : ones_a;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start_b = v;
    else start_a = v;
  endtask

  // Start a sweep on the selected instance and follow it to its done pulse.
  task automatic sweep(input int settle, input int glitch_at, input logic [15:0] exp_tbl_v,
                       input logic [4:0] exp_ones);
    int edges = 0;
    int vec_err = 0;
    int busy_err = 0;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    check_eq("busy_after_start", {31'b0, busy_s}, 32'd1);
    check_eq("tbl_cleared", {16'b0, tbl_s}, 32'd0);
    while (!done_s && edges < 16 * settle + 5) begin
      if (vec_s !== 4'(edges / settle)) vec_err++;
      if (busy_s !== 1'b1) busy_err++;
      @(posedge clk);
      #1;
      edges++;
      set_start(edges == glitch_at);
    end
    set_start(1'b0);
    check_eq("vec_hold_errs", vec_err, 0);
    check_eq("busy_hold_errs", busy_err, 0);
    check_eq("done_edge", edges, 16 * settle);
    check_eq("busy_at_done", {31'b0, busy_s}, 32'd0);
    check_eq("vec_at_done", {28'b0, vec_s}, 32'd0);
    check_eq("table_out", {16'b0, tbl_s}, {16'b0, exp_tbl_v});
    check_eq("ones_count", {27'b0, ones_s}, {27'b0, exp_ones});
    @(posedge clk);
    #1;
    check_eq("done_clears", {31'b0, done_s}, 32'd0);
    check_eq("table_held", {16'b0, tbl_s}, {16'b0, exp_tbl_v});
  endtask

  initial begin
    #12;
    check_eq("rst_busy", {31'b0, busy_a}, 32'd0);
    check_eq("rst_done", {31'b0, done_a}, 32'd0);
    check_eq("rst_vec", {28'b0, vec_a}, 32'd0);
    check_eq("rst_tbl", {16'b0, tbl_a}, 32'd0);
    check_eq("rst_ones", {27'b0, ones_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start and abort together in IDLE: stay idle
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    abort_a = 1'b0;
    check_eq("start_abort_idle", {31'b0, busy_a}, 32'd0);

    mode = 0; sel = 0;
    sweep(1, -1, 16'hFFFF, 5'd16);

    mode = 1; sel = 1;
    sweep(3, -1, 16'hAAAA, 5'd8);

    mode = 2; sel = 0;
    sweep(1, 5, 16'hF444, 5'd7);

    // abort while vec=5
    mode = 0; sel = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check_eq("abort_vec5", {28'b0, vec_a}, 32'd5);
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    check_eq("abort_busy", {31'b0, busy_a}, 32'd0);
    check_eq("abort_done", {31'b0, done_a}, 32'd0);
    check_eq("abort_vec", {28'b0, vec_a}, 32'd0);
    check_eq("abort_tbl", {16'b0, tbl_a}, 32'h001F);
    check_eq("abort_ones", {27'b0, ones_a}, 32'd5);
    @(posedge clk);
    #1;
    check_eq("abort_no_done", {31'b0, done_a}, 32'd0);

    // asynchronous reset while vec=9
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_mid_vec9", {28'b0, vec_a}, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'b0, busy_a}, 32'd0);
    check_eq("arst_vec", {28'b0, vec_a}, 32'd0);
    check_eq("arst_tbl", {16'b0, tbl_a}, 32'd0);
    check_eq("arst_ones", {27'b0, ones_a}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("arst_no_done", {31'b0, done_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2;
    sweep(1, -1, 16'hF444, 5'd7);

`ifdef EP01_EXPECT_CHECK_EN
    mode = 3; sel = 0;
    sweep(1, -1, 16'hAAFA, 5'd10);
    check_eq("mismatch", {31'b0, mis_a}, 32'd1);
    check_eq("first_err", {28'b0, ferr_a}, 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/ep01_sweep_capture.md
Name: ep01_sweep_capture

Overview:
- Sequential truth-table sweeper for the EP01 combinational exercises (ep01A/B/C-style f(a,b,c,d)).
- Sits upstream and downstream of the function under test: drives every input vector in ascending order, waits a settle interval, then samples f back.
- Produces the captured truth table as a packed word plus a count of ones, for on-board or bench self-checking of each exercise.

Parameters:
- N_IN, 4, number of function inputs; vec width; table width is 2**N_IN.
- SETTLE, 1, clock cycles each vector is held before f is sampled; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  cancel sweep; sampled only in RUN.
- f_in  input  1  output of the function under test.
- vec  output  N_IN  applied vector; vec[N_IN-1]=a (MSB) … vec[0]=d.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse on completion.
- table_out  output  2**N_IN  table_out[i] = f sampled with vec=i.
- ones_count  output  N_IN+1  number of ones in table_out.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state IDLE, vec=0, busy=0, done=0, table_out=0, ones_count=0, settle counter=0.
- States:
  - IDLE: on start=1 and abort=0, at edge E0: state RUN, busy=1, vec=0, cnt=0, table_out=0, ones_count=0.
  - RUN: each edge, if abort=1: state IDLE, busy=0, vec=0, done stays 0; table_out and ones_count keep the partial capture. Else if cnt==SETTLE-1: table_out[vec]<=f_in, ones_count<=ones_count+f_in, cnt<=0. If vec==2**N_IN-1 then state IDLE, busy<=0, done<=1, vec<=0; else vec<=vec+1. Otherwise cnt<=cnt+1.
- done is registered. It is high for exactly the cycle after the final sample edge, then clears.
- Timing: each vector is held for SETTLE cycles. Sample k occurs at edge E0+(k+1)*SETTLE. Final sample at E0+2**N_IN*SETTLE; done is high in the following cycle.
- start during RUN is ignored. start and abort both high in IDLE: stay IDLE.
- abort on the final sample edge wins: no sample is written and no done pulse.
- ones_count never overflows; its width holds 2**N_IN.
- table_out and ones_count are stable and valid from the done cycle until the next start edge.
- Reset mid-sweep: immediate return to reset values, no done pulse.

Optional Feature:
- Macro EP01_EXPECT_CHECK_EN.
- Defined: adds input expected[2**N_IN-1:0] and outputs mismatch (1) and first_err[N_IN-1:0].
  - Both are cleared at the start edge.
  - At each sample edge, if f_in != expected[vec]: mismatch<=1, and first_err<=vec if mismatch was still 0.
  - Values are held after done.
- Undefined: these ports and this logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then f_in tied 1, SETTLE=1, pulse start -> busy for 16 cycles, done pulse 17 edges after E0, table_out=16'hFFFF, ones_count=16, vec=0 after.
- f_in=vec[0], SETTLE=3 -> vec values 0..15 each held 3 cycles, done at E0+48+1, table_out=16'hAAAA, ones_count=8.
- f_in = a&b | c&~d modelled from vec -> table_out=16'hF444, ones_count=7; start pulsed mid-sweep has no effect.
- abort asserted while vec=5, SETTLE=1, f_in=1 -> IDLE next edge, busy=0, no done, table_out=16'h001F, ones_count=5.
- rst_n low while vec=9 -> all outputs zero immediately (asynchronous), no done; a new start after release gives a full correct sweep.
- With EP01_EXPECT_CHECK_EN, expected=16'hAAAA, f_in=vec[0] except forced 1 at vec=4 and vec=6 -> mismatch=1, first_err=4, table_out=16'hAAFA.
